// File: rtl/display_timings_pkg.sv
// display_timings_pkg
//   Display-mode timing table shared by display_timings and the board tops.
//   Board tops pick a mode number and pull RES/FP/SYNC/BP/POL from
//   mode_timing() rather than repeating raw numbers.
//   Contents:
//     mode_timing_t         one mode's horizontal/vertical timing and sync polarity
//     mode_timing()         mode number -> timing (unknown numbers fall back to mode 3)
//     DISPLAY_MODE_DEFAULT  mode used when no mode is chosen (672x384, 800x525 raster)
//     DEFAULT_MODE          timing of DISPLAY_MODE_DEFAULT
package display_timings_pkg;

    typedef struct packed {
        int h_res;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_res;
        int v_fp;
        int v_sync;
        int v_bp;
        bit h_pol;
        bit v_pol;
    } mode_timing_t;

    localparam int DISPLAY_MODE_DEFAULT = 3;

    function automatic mode_timing_t mode_timing(input int mode);
        mode_timing_t t;
        case (mode)
            0:       t = '{640,  16,  96,  48, 480, 10, 2, 33, 1'b0, 1'b0};  // 640x480 @ 25.2 MHz
            1:       t = '{800,  40, 128,  88, 600,  1, 4, 23, 1'b1, 1'b1};  // 800x600 @ 40 MHz
            2:       t = '{1280, 110, 40, 220, 720,  5, 5, 20, 1'b1, 1'b1};  // 1280x720 @ 74.25 MHz
            default: t = '{672,  16,  96,  16, 384, 63, 2, 76, 1'b0, 1'b0};  // 672x384 in 800x525 @ 25 MHz
        endcase
        return t;
    endfunction

    localparam mode_timing_t DEFAULT_MODE = mode_timing(DISPLAY_MODE_DEFAULT);

endpackage

// File: rtl/display_timings.sv
// display_timings
//   Raster timing generator on the pixel clock. Produces signed screen
//   coordinates (blanking first, negative values; active area from 0,0),
//   sync pulses, data enable and line/frame start strobes.
//   Ports:
//     clk_pix     in   pixel clock
//     rst_pix_n   in   asynchronous reset, active-low
//     disp_x      out  signed horizontal position, 0..H_RES-1 active
//     disp_y      out  signed vertical position, 0..V_RES-1 active
//     disp_hsync  out  horizontal sync, polarity H_POL
//     disp_vsync  out  vertical sync, polarity V_POL
//     disp_de     out  data enable (x and y both active)
//     disp_frame  out  strobe at first position of a frame
//     disp_line   out  strobe at first position of each line
module display_timings
    import display_timings_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int H_RES  = DEFAULT_MODE.h_res,
    parameter int H_FP   = DEFAULT_MODE.h_fp,
    parameter int H_SYNC = DEFAULT_MODE.h_sync,
    parameter int H_BP   = DEFAULT_MODE.h_bp,
    parameter int V_RES  = DEFAULT_MODE.v_res,
    parameter int V_FP   = DEFAULT_MODE.v_fp,
    parameter int V_SYNC = DEFAULT_MODE.v_sync,
    parameter int V_BP   = DEFAULT_MODE.v_bp,
    parameter bit H_POL  = DEFAULT_MODE.h_pol,
    parameter bit V_POL  = DEFAULT_MODE.v_pol
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    output logic signed [CORDW-1:0] disp_x,
    output logic signed [CORDW-1:0] disp_y,
    output logic                    disp_hsync,
    output logic                    disp_vsync,
    output logic                    disp_de,
    output logic                    disp_frame,
    output logic                    disp_line
);

    localparam int H_BLANK  = H_FP + H_SYNC + H_BP;
    localparam int V_BLANK  = V_FP + V_SYNC + V_BP;
    localparam int CORD_MAX = (CORDW >= 2 && CORDW <= 31) ? (1 << (CORDW - 1)) - 1 : 0;

    if (CORDW < 2 || CORDW > 31) begin : g_bad_cordw
        $error("display_timings: CORDW must be in 2..31");
    end
    if (H_RES == 0 || H_SYNC == 0 || V_RES == 0 || V_SYNC == 0) begin : g_bad_zero
        $error("display_timings: H_RES, H_SYNC, V_RES and V_SYNC must be non-zero");
    end
    if (H_BLANK > CORD_MAX + 1 || V_BLANK > CORD_MAX + 1 ||
        H_RES - 1 > CORD_MAX || V_RES - 1 > CORD_MAX) begin : g_bad_range
        $error("display_timings: coordinate range does not fit in CORDW bits");
    end

    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-H_BLANK);
    localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-V_BLANK);
    localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] HS_BEG = CORDW'(H_FP - H_BLANK);
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(H_FP + H_SYNC - 1 - H_BLANK);
    localparam logic signed [CORDW-1:0] VS_BEG = CORDW'(V_FP - V_BLANK);
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(V_FP + V_SYNC - 1 - V_BLANK);
    localparam logic signed [CORDW-1:0] ZERO   = '0;
    localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);

    // Position that the outputs will present after the next clock. Decoding
    // this rather than disp_x/disp_y keeps every output aligned to the same
    // coordinate, and lets the first clock after reset present (H_STA,V_STA)
    // with both strobes set.
    logic signed [CORDW-1:0] x_nxt;
    logic signed [CORDW-1:0] y_nxt;
    logic signed [CORDW-1:0] x_adv;
    logic signed [CORDW-1:0] y_adv;

    always_comb begin
        x_adv = x_nxt + ONE;
        y_adv = y_nxt;
        if (x_nxt == H_END) begin
            x_adv = H_STA;
            y_adv = (y_nxt == V_END) ? V_STA : y_nxt + ONE;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            x_nxt      <= H_STA;
            y_nxt      <= V_STA;
            disp_x     <= H_STA;
            disp_y     <= V_STA;
            disp_hsync <= ~H_POL;
            disp_vsync <= ~V_POL;
            disp_de    <= 1'b0;
            disp_frame <= 1'b0;
            disp_line  <= 1'b0;
        end else begin
            x_nxt      <= x_adv;
            y_nxt      <= y_adv;
            disp_x     <= x_nxt;
            disp_y     <= y_nxt;
            disp_hsync <= (x_nxt >= HS_BEG && x_nxt <= HS_END) ? H_POL : ~H_POL;
            disp_vsync <= (y_nxt >= VS_BEG && y_nxt <= VS_END) ? V_POL : ~V_POL;
            // x and y never exceed their END values, so only the lower bound matters.
            disp_de    <= (x_nxt >= ZERO) && (y_nxt >= ZERO);
            disp_frame <= (x_nxt == H_STA) && (y_nxt == V_STA);
            disp_line  <= (x_nxt == H_STA);
        end
    end

endmodule
